// File: rtl/ex_stage_mc.sv
// MIPS execute stage: owns the EX/MEM register and an iterative MULT/DIV unit with HI/LO.
// ALU instructions keep issuing while MULT/DIV runs; only MFHI/MFLO and a new MULT/DIV wait.
module ex_stage_mc #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_stall_mem,
    input  logic               i_flush,
    input  logic               i_con_regdst,
    input  logic               i_con_alusrc,
    input  logic               i_con_branch,
    input  logic               i_con_memread,
    input  logic               i_con_memwrite,
    input  logic               i_con_memtoreg,
    input  logic               i_con_regwrite,
    input  logic [1:0]         i_con_aluop,
    input  logic [DATA_W-1:0]  i_addr_NextPC,
    input  logic [DATA_W-1:0]  i_data_rs,
    input  logic [DATA_W-1:0]  i_data_rt,
    input  logic [DATA_W-1:0]  i_data_SignExt,
    input  logic [RADDR_W-1:0] i_addr_mux_0,
    input  logic [RADDR_W-1:0] i_addr_mux_1,
    output logic               o_valid,
    output logic               o_con_branch,
    output logic               o_con_memread,
    output logic               o_con_memwrite,
    output logic               o_con_memtoreg,
    output logic               o_con_regwrite,
    output logic [DATA_W-1:0]  o_data_AddRst,
    output logic [DATA_W-1:0]  o_data_ALU_Rst,
    output logic [DATA_W-1:0]  o_data_rt,
    output logic               o_con_Zero,
    output logic [RADDR_W-1:0] o_addr_MuxRst,
    output logic               o_busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {ST_IDLE, ST_RUN} md_state_t;

    md_state_t            md_state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*DATA_W-1:0]  acc_q;
    logic [DATA_W-1:0]    opnd_q;
    logic                 is_div_q, neg_q, rem_neg_q, divzero_q;
    logic [DATA_W-1:0]    hi_q, lo_q;

    logic [5:0]           funct;
    logic                 is_mf, is_md, accept, launch, slt_bit;
    logic [DATA_W-1:0]    b_op, alu_res, branch_tgt;
    logic                 md_signed, a_neg, b_neg;
    logic [DATA_W-1:0]    a_mag, b_mag;
    logic [DATA_W:0]      mul_sum, rem_sh, diff;
    logic [2*DATA_W-1:0]  mul_next, div_next, step_next, mul_fix;
    logic [DATA_W-1:0]    q_fix, r_fix;

    assign funct   = i_data_SignExt[5:0];
    assign is_mf   = (i_con_aluop == 2'b10) && (funct == 6'h10 || funct == 6'h12);
    assign is_md   = (i_con_aluop == 2'b10) && (funct[5:2] == 4'b0110);
    assign o_busy  = (md_state_q == ST_RUN);
    assign o_ready = !i_stall_mem && !(o_busy && (is_mf || is_md));
    assign accept  = i_valid && o_ready && !i_flush;
    assign launch  = accept && is_md;

    assign b_op       = i_con_alusrc ? i_data_SignExt : i_data_rt;
    assign branch_tgt = i_addr_NextPC + (i_data_SignExt << 2);
    assign slt_bit    = $signed(i_data_rs) < $signed(b_op);

    always_comb begin
        alu_res = i_data_rs + b_op;
        if (i_con_aluop == 2'b01) begin
            alu_res = i_data_rs - b_op;
        end else if (i_con_aluop == 2'b10) begin
            case (funct)
                6'h22:   alu_res = i_data_rs - b_op;
                6'h24:   alu_res = i_data_rs & b_op;
                6'h25:   alu_res = i_data_rs | b_op;
                6'h2A:   alu_res = {{(DATA_W-1){1'b0}}, slt_bit};
                6'h10:   alu_res = hi_q;
                6'h12:   alu_res = lo_q;
                default: alu_res = i_data_rs + b_op;
            endcase
        end
    end

    // Operand magnitudes; funct[0]=0 selects the signed variants.
    assign md_signed = !funct[0];
    assign a_neg     = md_signed && i_data_rs[DATA_W-1];
    assign b_neg     = md_signed && i_data_rt[DATA_W-1];
    assign a_mag     = a_neg ? -i_data_rs : i_data_rs;
    assign b_mag     = b_neg ? -i_data_rt : i_data_rt;

    // acc_q holds {partial product, multiplier} or {remainder, quotient}.
    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};
    assign rem_sh   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign diff     = rem_sh - {1'b0, opnd_q};
    assign div_next = diff[DATA_W] ? {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                   : {diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    assign step_next = is_div_q ? div_next : mul_next;

    // Divide by zero keeps the all-ones quotient; remainder sign fix restores the dividend.
    assign mul_fix = neg_q ? -step_next : step_next;
    assign q_fix   = (neg_q && !divzero_q) ? -step_next[DATA_W-1:0] : step_next[DATA_W-1:0];
    assign r_fix   = rem_neg_q ? -step_next[2*DATA_W-1:DATA_W] : step_next[2*DATA_W-1:DATA_W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            md_state_q <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            divzero_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (md_state_q)
                ST_IDLE: begin
                    if (launch) begin
                        md_state_q <= ST_RUN;
                        cnt_q      <= CNT_W'(DATA_W);
                        acc_q      <= {{DATA_W{1'b0}}, a_mag};
                        opnd_q     <= b_mag;
                        is_div_q   <= funct[1];
                        neg_q      <= a_neg ^ b_neg;
                        rem_neg_q  <= a_neg;
                        divzero_q  <= (i_data_rt == '0);
                    end
                end
                ST_RUN: begin
                    acc_q <= step_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        md_state_q <= ST_IDLE;
                        if (is_div_q) begin
                            hi_q <= r_fix;
                            lo_q <= q_fix;
                        end else begin
                            hi_q <= mul_fix[2*DATA_W-1:DATA_W];
                            lo_q <= mul_fix[DATA_W-1:0];
                        end
                    end
                end
                default: md_state_q <= ST_IDLE;
            endcase
        end
    end

    // EX/MEM register: hold on stall, load on accept, otherwise insert a bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid        <= 1'b0;
            o_con_branch   <= 1'b0;
            o_con_memread  <= 1'b0;
            o_con_memwrite <= 1'b0;
            o_con_memtoreg <= 1'b0;
            o_con_regwrite <= 1'b0;
            o_data_AddRst  <= '0;
            o_data_ALU_Rst <= '0;
            o_data_rt      <= '0;
            o_con_Zero     <= 1'b0;
            o_addr_MuxRst  <= '0;
        end else if (!i_stall_mem) begin
            if (accept) begin
                o_valid        <= 1'b1;
                o_con_branch   <= i_con_branch;
                o_con_memread  <= i_con_memread;
                o_con_memwrite <= i_con_memwrite;
                o_con_memtoreg <= i_con_memtoreg;
                o_con_regwrite <= i_con_regwrite;
                o_data_AddRst  <= branch_tgt;
                o_data_ALU_Rst <= alu_res;
                o_data_rt      <= i_data_rt;
                o_con_Zero     <= (alu_res == '0);
                o_addr_MuxRst  <= i_con_regdst ? i_addr_mux_1 : i_addr_mux_0;
            end else begin
                o_valid        <= 1'b0;
                o_con_branch   <= 1'b0;
                o_con_memread  <= 1'b0;
                o_con_memwrite <= 1'b0;
                o_con_memtoreg <= 1'b0;
                o_con_regwrite <= 1'b0;
                o_con_Zero     <= 1'b0;
            end
        end
    end

endmodule
